lcd_hd44780_ctrl: RTL

//  Parametrised HD44780 character-LCD controller, next generation of our 4-bit LCD driver. Runs the power-up/init sequence,

---
 rtl/lcd_hd44780_ctrl_if.sv | 9 +
 rtl/lcd_hd44780_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_ctrl_if.sv
// lcd_hd44780_ctrl_if: CPU-side valid/ready request port of the HD44780 controller
interface lcd_hd44780_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready);
    modport slave (input cmd_valid, cmd_op, cmd_data, output cmd_ready);
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl: HD44780 character-LCD controller with power-up init and a valid/ready command port
module lcd_hd44780_ctrl #(
    parameter int CLK_MHZ    = 100,
    parameter int BUS_WIDTH  = 4,
    parameter int LINES      = 2,
    parameter int POWERUP_MS = 130,
    parameter int WAKE_US    = 5000,
    parameter int EN_US      = 1,
    parameter int CMD_US     = 50,
    parameter int LONG_US    = 2000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    lcd_hd44780_ctrl_if.slave    cmd,
    output logic                 lcd_rs,
    output logic                 lcd_en,
    output logic [BUS_WIDTH-1:0] lcd_db,
    output logic                 init_done
);
    localparam int PWR_RAW  = POWERUP_MS * 1000 * CLK_MHZ;
    localparam int PWR_CYC  = (PWR_RAW < 1) ? 1 : PWR_RAW;
    localparam int WAKE_CYC = (WAKE_US * CLK_MHZ < 1) ? 1 : WAKE_US * CLK_MHZ;
    localparam int EN_CYC   = (EN_US * CLK_MHZ < 1) ? 1 : EN_US * CLK_MHZ;
    localparam int CMD_CYC  = (CMD_US * CLK_MHZ < 1) ? 1 : CMD_US * CLK_MHZ;
    localparam int LONG_CYC = (LONG_US * CLK_MHZ < 1) ? 1 : LONG_US * CLK_MHZ;
    localparam int MAX_A    = (POWERUP_MS * 1000 > LONG_US) ? POWERUP_MS * 1000 : LONG_US;
    localparam int MAX_US   = (MAX_A > WAKE_US) ? MAX_A : WAKE_US;
    localparam int CW_RAW   = $clog2(MAX_US * CLK_MHZ + 1);
    localparam int CW       = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] L_PWR  = CW'(PWR_CYC - 1);
    localparam logic [CW-1:0] L_WAKE = CW'(WAKE_CYC - 1);
    localparam logic [CW-1:0] L_EN   = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] L_CMD  = CW'(CMD_CYC - 1);
    localparam logic [CW-1:0] L_LONG = CW'(LONG_CYC - 1);
    localparam logic [7:0] FUNC_SET = 8'h20 | ((BUS_WIDTH == 8) ? 8'h10 : 8'h00) | ((LINES > 1) ? 8'h08 : 8'h00);
    // init steps 0..7: three wake writes, the 4-bit switch nibble, then the four init bytes
    localparam logic [63:0] INIT_TAB = {8'h06, 8'h01, 8'h0C, FUNC_SET, 8'h20, 8'h30, 8'h30, 8'h30};

    if (BUS_WIDTH != 4 && BUS_WIDTH != 8) begin : g_bad_width
        $error("lcd_hd44780_ctrl: BUS_WIDTH must be 4 or 8");
    end

    typedef enum logic [2:0] {PWR_WAIT, SETUP, EN_HI, EN_LO, EXEC_WAIT, IDLE} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n, lim, wait_lim;
    logic [7:0]     byte_q, byte_n, op_byte;
    logic [2:0]     step, step_n, nxt_step;
    logic [1:0]     row;
    logic [6:0]     off, pos;
    logic           rs_q, rs_n, hi_q, hi_n, single_q, single_n, done_n, tick;
    logic           en_d, rs_d, ready_d;
    logic [BUS_WIDTH-1:0] db_d;

    assign row      = (LINES == 4) ? cmd.cmd_data[7:6] : (LINES == 2) ? {1'b0, cmd.cmd_data[6]} : 2'd0;
    assign off      = (row == 2'd0) ? 7'h00 : (row == 2'd1) ? 7'h40 : (row == 2'd2) ? 7'h14 : 7'h54;
    assign pos      = off + {1'b0, cmd.cmd_data[5:0]};
    assign op_byte  = cmd.cmd_op[1] ? (cmd.cmd_op[0] ? {1'b1, pos} : 8'h01) : cmd.cmd_data;
    assign nxt_step = (BUS_WIDTH == 8 && step == 3'd2) ? 3'd4 : step + 3'd1;
    assign wait_lim = (!init_done && step < 3'd3) ? L_WAKE
                    : (!rs_q && byte_q[7:2] == 6'd0 && byte_q[1:0] != 2'd0) ? L_LONG : L_CMD;
    assign lim      = (state == PWR_WAIT) ? L_PWR : (state == EN_HI || state == EN_LO) ? L_EN
                    : (state == EXEC_WAIT) ? wait_lim : '0;
    assign tick     = cnt == lim;

    // State, datapath and registered outputs; outputs load from the next-state view so they line up with state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= PWR_WAIT;
            cnt           <= '0;
            byte_q        <= '0;
            rs_q          <= 1'b0;
            hi_q          <= 1'b1;
            single_q      <= 1'b0;
            step          <= '0;
            init_done     <= 1'b0;
            lcd_rs        <= 1'b0;
            lcd_en        <= 1'b0;
            lcd_db        <= '0;
            cmd.cmd_ready <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            byte_q        <= byte_n;
            rs_q          <= rs_n;
            hi_q          <= hi_n;
            single_q      <= single_n;
            step          <= step_n;
            init_done     <= done_n;
            lcd_rs        <= rs_d;
            lcd_en        <= en_d;
            lcd_db        <= db_d;
            cmd.cmd_ready <= ready_d;
        end
    end

    // Sequencing: every timed state leaves on counter tick; init steps and accepted requests feed the write engine
    always_comb begin
        state_n  = state;
        cnt_n    = tick ? '0 : cnt + 1'b1;
        byte_n   = byte_q;
        rs_n     = rs_q;
        hi_n     = hi_q;
        single_n = single_q;
        step_n   = step;
        done_n   = init_done;
        case (state)
            PWR_WAIT: if (tick) begin
                state_n  = SETUP;
                byte_n   = INIT_TAB[7:0];
                rs_n     = 1'b0;
                hi_n     = 1'b1;
                single_n = 1'b1;
            end
            SETUP: state_n = EN_HI;
            EN_HI: if (tick) state_n = EN_LO;
            EN_LO: if (tick) begin
                if (BUS_WIDTH == 4 && hi_q && !single_q) begin
                    state_n = SETUP;
                    hi_n    = 1'b0;
                end else begin
                    state_n = EXEC_WAIT;
                end
            end
            EXEC_WAIT: if (tick) begin
                if (init_done || step == 3'd7) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n  = SETUP;
                    step_n   = nxt_step;
                    byte_n   = INIT_TAB[{nxt_step, 3'b000} +: 8];
                    hi_n     = 1'b1;
                    single_n = nxt_step < 3'd4;
                end
            end
            IDLE: if (cmd.cmd_valid && cmd.cmd_ready) begin
                state_n  = SETUP;
                byte_n   = op_byte;
                rs_n     = cmd.cmd_op == 2'b00;
                hi_n     = 1'b1;
                single_n = 1'b0;
            end
            default: state_n = PWR_WAIT;
        endcase
    end

    // Output decode: rs/db only change when entering SETUP, so they are stable around every enable pulse
    always_comb begin
        en_d    = state_n == EN_HI;
        rs_d    = (state_n == SETUP) ? rs_n : lcd_rs;
        db_d    = (state_n == SETUP) ? (hi_n ? byte_n[7 -: BUS_WIDTH] : byte_n[BUS_WIDTH-1:0]) : lcd_db;
        ready_d = state_n == IDLE && done_n;
    end
endmodule
